spp_run_sequencer: RTL and testbench

- Hardware initiator for single-purpose-processor blocks that use the go/done/result handshake.
- Issues a batch of go pulses to one responder, one run at a time, and waits for done after each.
- Captures each result together with its measured cycle latency into a small first-word-fall-through (FWFT) FIFO.
- Replaces the manual go/monitor/done loop in bring-up and in regression benches.

---
 rtl/spp_run_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_spp_run_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spp_run_sequencer.sv
// -----------------------------------------------------------------------------
// spp_run_sequencer
//
// Drives a batch of go pulses to a single go/done/result responder, one run at
// a time. For each run it measures the number of cycles from go to done and
// stores {result, latency} in a small first-word-fall-through FIFO.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   start        batch request, only accepted while idle
//   num_runs     number of runs in the batch, latched when start is accepted
//   go_o         one-cycle go pulse to the responder
//   done_i       responder completion flag
//   result_i     responder result, valid while done_i is high
//   rd_en        pop the FIFO head (ignored while empty)
//   rd_data      {result, latency} at the FIFO head, zero while empty
//   fifo_empty   FIFO holds no entries
//   fifo_full    FIFO holds DEPTH entries
//   busy         sequencer is not idle
//   batch_done   one-cycle pulse when a batch completes normally
//   timeout_err  sticky abort flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module spp_run_sequencer #(
  parameter int RESULT_W = 16,
  parameter int LAT_W    = 12,
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                num_runs,
  output logic                      go_o,
  input  logic                      done_i,
  input  logic [RESULT_W-1:0]       result_i,
  input  logic                      rd_en,
  output logic [RESULT_W+LAT_W-1:0] rd_data,
  output logic                      fifo_empty,
  output logic                      fifo_full,
  output logic                      busy,
  output logic                      batch_done,
  output logic                      timeout_err
);

  localparam int ENTRY_W = RESULT_W + LAT_W;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  localparam logic [LAT_W-1:0] TIMEOUT_L = LAT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] DEPTH_L   = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  // Sequencer state
  logic [1:0]          state_q, state_d;
  logic [7:0]          rem_q, rem_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [LAT_W-1:0]    lat_inc;
  logic [RESULT_W-1:0] res_q, res_d;
  logic                go_q, busy_q;
  logic                batch_done_q, batch_done_d;
  logic                timeout_err_q, timeout_err_d;

  // FIFO state
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                push, pop;

  assign lat_inc = lat_q + LAT_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    lat_d         = lat_q;
    res_d         = res_q;
    timeout_err_d = timeout_err_q;
    batch_done_d  = 1'b0;
    push          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d         = num_runs;
          timeout_err_d = 1'b0;
          if (num_runs == 8'd0) begin
            batch_done_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        lat_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // lat_q ends up holding the latency of the completed run, so the
        // FIFO entry can be built straight from res_q/lat_q in STORE.
        lat_d = lat_inc;
        if (done_i) begin
          res_d   = result_i;
          state_d = S_STORE;
        end else if (lat_inc == TIMEOUT_L) begin
          timeout_err_d = 1'b1;
          rem_d         = '0;
          state_d       = S_IDLE;
        end
      end

      S_STORE: begin
        // A full FIFO still accepts the entry if the head is popped this cycle.
        if (!fifo_full || rd_en) begin
          push  = 1'b1;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            state_d      = S_IDLE;
            batch_done_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      rem_q         <= '0;
      lat_q         <= '0;
      res_q         <= '0;
      go_q          <= 1'b0;
      busy_q        <= 1'b0;
      batch_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      lat_q         <= lat_d;
      res_q         <= res_d;
      go_q          <= (state_d == S_ISSUE);
      busy_q        <= (state_d != S_IDLE);
      batch_done_q  <= batch_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign go_o        = go_q;
  assign busy        = busy_q;
  assign batch_done  = batch_done_q;
  assign timeout_err = timeout_err_q;

  // ---------------------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_L);
  assign pop        = rd_en && !fifo_empty;
  assign rd_data    = fifo_empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the occupancy count alone decides
  // which slots are valid, and rd_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {res_q, lat_q};
  end

endmodule

// File: tb/tb_spp_run_sequencer.sv
// -----------------------------------------------------------------------------
// Directed bench for spp_run_sequencer. A responder model answers each go pulse
// after a programmable delay with a result taken from a table; a monitor logs
// go pulses and batch_done pulses with their cycle numbers. Inputs change and
// outputs are sampled just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spp_run_sequencer;

  localparam int RESULT_W = 16;
  localparam int LAT_W    = 12;
  localparam int DEPTH    = 4;
  localparam int TIMEOUT  = 1000;
  localparam int ENTRY_W  = RESULT_W + LAT_W;

  logic                clk      = 1'b0;
  logic                reset    = 1'b0;
  logic                start    = 1'b0;
  logic [7:0]          num_runs = 8'd0;
  logic                done_i   = 1'b0;
  logic [RESULT_W-1:0] result_i = '0;
  logic                rd_en    = 1'b0;
  logic                go_o;
  logic [ENTRY_W-1:0]  rd_data;
  logic                fifo_empty, fifo_full, busy, batch_done, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor / responder bookkeeping
  int cyc        = 0;
  int go_count   = 0;
  int bd_count   = 0;
  int bd_t       = 0;
  int cd         = -1;
  int resp_delay = 0;
  int go_t [64];
  logic [RESULT_W-1:0] resp_res [64];

  spp_run_sequencer #(
    .RESULT_W(RESULT_W),
    .LAT_W   (LAT_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_runs   (num_runs),
    .go_o       (go_o),
    .done_i     (done_i),
    .result_i   (result_i),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .batch_done (batch_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Responder: a go seen in cycle c raises done for exactly cycle c+delay.
  // A delay of 0 means the responder never answers.
  always @(negedge clk) begin
    cyc++;
    if (cd > 0) begin
      cd--;
      if (cd == 0) done_i = 1'b1;
    end else if (cd == 0) begin
      done_i = 1'b0;
      cd     = -1;
    end
    if (go_o === 1'b1) begin
      go_t[go_count % 64] = cyc;
      result_i = resp_res[go_count % 64];
      if (resp_delay > 0) cd = resp_delay;
      go_count++;
    end
    if (batch_done === 1'b1) begin
      bd_count++;
      bd_t = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ent(input int r, input int l);
    return (64'(r) << LAT_W) | 64'(l);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(busy), 64'(0));
  endtask

  task automatic wait_go(input int target, input int budget, input string tag);
    int n = 0;
    while (go_count < target && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(go_count >= target), 64'(1));
  endtask

  task automatic pop_check(input string tag, input logic [63:0] exp);
    check(tag, 64'(rd_data), exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b;
    int bd0;

    // ---------------- Reset state ----------------
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    check("rst_busy",    64'(busy),        64'(0));
    check("rst_go",      64'(go_o),        64'(0));
    check("rst_bd",      64'(batch_done),  64'(0));
    check("rst_to",      64'(timeout_err), 64'(0));
    check("rst_empty",   64'(fifo_empty),  64'(1));
    check("rst_full",    64'(fifo_full),   64'(0));
    check("rst_rd_data", 64'(rd_data),     64'(0));

    // ---------------- Three runs, done 5 cycles after go ----------------
    b   = go_count;
    bd0 = bd_count;
    resp_delay = 5;
    resp_res[(b + 0) % 64] = 16'd10;
    resp_res[(b + 1) % 64] = 16'd20;
    resp_res[(b + 2) % 64] = 16'd30;
    num_runs = 8'd3;
    start    = 1'b1;
    step();
    start    = 1'b0;
    check("t1_go_first", 64'(go_o), 64'(1));
    check("t1_busy",     64'(busy), 64'(1));
    wait_idle(100, "t1_idle");
    check("t1_go_count", 64'(go_count - b), 64'(3));
    check("t1_space_12", 64'(go_t[(b + 1) % 64] - go_t[b % 64]), 64'(7));
    check("t1_space_23", 64'(go_t[(b + 2) % 64] - go_t[(b + 1) % 64]), 64'(7));
    check("t1_bd_count", 64'(bd_count - bd0), 64'(1));
    // STORE of run 3 is 6 cycles after its go; the pushed entry and the
    // batch_done pulse both appear one cycle later.
    check("t1_bd_time",  64'(bd_t - go_t[(b + 2) % 64]), 64'(7));
    check("t1_full",     64'(fifo_full), 64'(0));
    pop_check("t1_e0", ent(10, 5));
    pop_check("t1_e1", ent(20, 5));
    pop_check("t1_e2", ent(30, 5));
    check("t1_empty",    64'(fifo_empty), 64'(1));

    // ---------------- Six runs into a 4-deep FIFO, no reads ----------------
    b   = go_count;
    bd0 = bd_count;
    resp_delay = 1;
    for (int i = 0; i < 6; i++) resp_res[(b + i) % 64] = RESULT_W'(101 + i);
    num_runs = 8'd6;
    start    = 1'b1;
    step();
    start    = 1'b0;
    wait_go(b + 5, 60, "t2_go5");
    repeat (8) step();
    // Run 5 was issued after the fourth push and is now parked in STORE;
    // nothing further may be issued while the FIFO stays full.
    check("t2_stall_gos",  64'(go_count - b),   64'(5));
    check("t2_stall_full", 64'(fifo_full),      64'(1));
    check("t2_stall_busy", 64'(busy),           64'(1));
    check("t2_stall_bd",   64'(bd_count - bd0), 64'(0));
    rd_en = 1'b1;
    check("t2_head_a", 64'(rd_data), ent(101, 1));
    step();
    check("t2_head_b", 64'(rd_data), ent(102, 1));
    step();
    rd_en = 1'b0;
    wait_idle(40, "t2_idle");
    check("t2_go_count", 64'(go_count - b),   64'(6));
    check("t2_bd_count", 64'(bd_count - bd0), 64'(1));
    check("t2_full_end", 64'(fifo_full),      64'(1));
    pop_check("t2_e3", ent(103, 1));
    pop_check("t2_e4", ent(104, 1));
    pop_check("t2_e5", ent(105, 1));
    pop_check("t2_e6", ent(106, 1));
    check("t2_empty", 64'(fifo_empty), 64'(1));

    // ---------------- Responder never answers ----------------
    b   = go_count;
    bd0 = bd_count;
    resp_delay = 0;
    resp_res[b % 64] = 16'hdead;
    num_runs = 8'd2;
    start    = 1'b1;
    step();
    start    = 1'b0;
    check("t3_go", 64'(go_o), 64'(1));
    wait_idle(1100, "t3_idle");
    // go in cycle c, WAIT cycles c+1..c+1000, idle with the flag at c+1001.
    check("t3_to_time",  64'(cyc - go_t[b % 64]), 64'(TIMEOUT + 1));
    check("t3_to_flag",  64'(timeout_err),        64'(1));
    check("t3_go_count", 64'(go_count - b),       64'(1));
    check("t3_no_bd",    64'(bd_count - bd0),     64'(0));
    check("t3_no_push",  64'(fifo_empty),         64'(1));
    repeat (3) step();
    check("t3_sticky",   64'(timeout_err),        64'(1));
    check("t3_no_more",  64'(go_count - b),       64'(1));

    // ---------------- Zero-run batch (also clears timeout_err) ----------------
    b   = go_count;
    bd0 = bd_count;
    num_runs = 8'd0;
    start    = 1'b1;
    step();
    start    = 1'b0;
    check("t6_bd",       64'(batch_done),  64'(1));
    check("t6_to_clear", 64'(timeout_err), 64'(0));
    check("t6_busy",     64'(busy),        64'(0));
    check("t6_go",       64'(go_o),        64'(0));
    step();
    check("t6_bd_off",   64'(batch_done),  64'(0));
    check("t6_busy2",    64'(busy),        64'(0));
    check("t6_bd_count", 64'(bd_count - bd0), 64'(1));
    check("t6_go_count", 64'(go_count - b),   64'(0));

    // ---------------- Reset during WAIT of run 2 of 4 ----------------
    b   = go_count;
    bd0 = bd_count;
    resp_delay = 5;
    for (int i = 0; i < 4; i++) resp_res[(b + i) % 64] = RESULT_W'(16'h0a01 + i);
    num_runs = 8'd4;
    start    = 1'b1;
    step();
    start    = 1'b0;
    wait_go(b + 2, 40, "t4_go2");
    step();
    step();
    check("t4_pre_fifo", 64'(fifo_empty), 64'(0));
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("t4_busy",    64'(busy),       64'(0));
    check("t4_empty",   64'(fifo_empty), 64'(1));
    check("t4_full",    64'(fifo_full),  64'(0));
    check("t4_rd_data", 64'(rd_data),    64'(0));
    repeat (12) step();
    check("t4_no_go",    64'(go_count - b),   64'(2));
    check("t4_empty2",   64'(fifo_empty),     64'(1));
    check("t4_busy2",    64'(busy),           64'(0));
    check("t4_no_bd",    64'(bd_count - bd0), 64'(0));

    // ---------------- rd_en while empty, start while busy ----------------
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t5_empty_rd", 64'(fifo_empty), 64'(1));
    check("t5_rd_zero",  64'(rd_data),    64'(0));
    b   = go_count;
    bd0 = bd_count;
    resp_delay = 2;
    resp_res[(b + 0) % 64] = 16'h0111;
    resp_res[(b + 1) % 64] = 16'h0222;
    num_runs = 8'd2;
    start    = 1'b1;
    step();
    num_runs = 8'd5;
    repeat (4) step();
    start    = 1'b0;
    wait_idle(40, "t5_idle");
    check("t5_go_count", 64'(go_count - b),   64'(2));
    check("t5_bd_count", 64'(bd_count - bd0), 64'(1));
    pop_check("t5_e0", ent(16'h0111, 2));
    pop_check("t5_e1", ent(16'h0222, 2));
    check("t5_empty", 64'(fifo_empty), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
